// File: rtl/hamming_secded_pipe.sv
// Two-stage SECDED Hamming codec: stage 1 encodes and optionally injects errors,
// stage 2 computes the syndrome, corrects single errors and extracts the data word.
module hamming_secded_pipe #(
  parameter int DATA_W = 32,
  parameter int PAR_W  = 6,
  parameter int CNT_W  = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_W-1:0]                 in_data,
  input  logic [1:0]                        inj_mode,
  input  logic [$clog2(DATA_W+PAR_W+1)-1:0] inj_pos,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_W-1:0]                 out_data,
  output logic                              out_single,
  output logic                              out_double,
  output logic [PAR_W-1:0]                  out_syndrome,
  input  logic                              clr_cnt,
  output logic [CNT_W-1:0]                  single_cnt,
  output logic [CNT_W-1:0]                  double_cnt
);
  localparam int CW    = DATA_W + PAR_W + 1;
  localparam int POS_W = $clog2(CW);
  localparam logic [CW-1:0]    ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [POS_W:0]   CW_P = (POS_W+1)'(CW);
  localparam logic [PAR_W:0]   CW_S = (PAR_W+1)'(CW);

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  // Data index carried by Hamming position p.
  function automatic int data_idx(input int p);
    int n;
    n = 0;
    for (int i = 1; i < p; i++)
      if (!is_pow2(i)) n++;
    return n;
  endfunction

  // Hamming position holding data bit j.
  function automatic int data_pos(input int j);
    int n;
    int r;
    n = 0;
    r = 0;
    for (int i = 1; i < CW; i++) begin
      if (!is_pow2(i)) begin
        if (n == j) r = i;
        n++;
      end
    end
    return r;
  endfunction

  function automatic logic [CW-1:0] mask_of(input int b);
    logic [CW-1:0] m;
    m = '0;
    for (int i = 1; i < CW; i++)
      if ((i & b) != 0) m = m | (ONE << i);
    return m;
  endfunction

  logic [CW-1:1] enc_raw;
  logic [CW-1:1] enc_hp;
  logic [CW-1:0] enc;
  logic [CW-1:0] inj_mask;
  logic [CW-1:0] cw1;

  for (genvar p = 1; p < CW; p++) begin : g_enc
    if (is_pow2(p)) begin : g_par
      localparam logic [CW-1:0] PM = mask_of(p);
      assign enc_raw[p] = 1'b0;
      assign enc_hp[p]  = ^(enc_raw & PM[CW-1:1]);
    end else if (data_idx(p) < DATA_W) begin : g_dat
      localparam int DI = data_idx(p);
      assign enc_raw[p] = in_data[DI];
      assign enc_hp[p]  = in_data[DI];
    end else begin : g_pad
      assign enc_raw[p] = 1'b0;
      assign enc_hp[p]  = 1'b0;
    end
  end

  assign enc = {enc_hp, ^enc_hp};

  logic [POS_W:0]   pos_nxt_raw;
  logic [POS_W-1:0] pos_nxt;

  // The second flip of a double injection wraps around the codeword.
  always_comb begin
    pos_nxt_raw = {1'b0, inj_pos} + (POS_W+1)'(1);
    if (pos_nxt_raw >= CW_P) pos_nxt_raw = pos_nxt_raw - CW_P;
    pos_nxt = pos_nxt_raw[POS_W-1:0];
    case (inj_mode)
      2'b01:   inj_mask = ONE << inj_pos;
      2'b10:   inj_mask = (ONE << inj_pos) | (ONE << pos_nxt);
      default: inj_mask = '0;
    endcase
  end

  logic [PAR_W-1:0]  syn;
  logic              par;
  logic              syn_in_rng;
  logic              dec_single;
  logic              dec_double;
  logic [DATA_W-1:0] dec_data;

  for (genvar k = 0; k < PAR_W; k++) begin : g_syn
    localparam logic [CW-1:0] SM = mask_of(1 << k);
    assign syn[k] = ^(cw1 & SM);
  end

  always_comb begin
    par        = ^cw1;
    syn_in_rng = {1'b0, syn} < CW_S;
    dec_single = par & syn_in_rng;
    dec_double = (par & !syn_in_rng) | (!par & (syn != '0));
  end

  // A syndrome naming a data position flips that bit on the way out.
  for (genvar j = 0; j < DATA_W; j++) begin : g_ext
    localparam logic [PAR_W-1:0] DPS = PAR_W'(data_pos(j));
    assign dec_data[j] = cw1[data_pos(j)] ^ (dec_single & (syn == DPS));
  end

  logic v1;
  logic v2;
  logic adv1;
  logic adv2;
  logic accept;
  logic ld2;

  assign adv2      = !v2 | out_ready;
  assign adv1      = !v1 | adv2;
  assign in_ready  = adv1;
  assign accept    = in_valid & in_ready;
  assign ld2       = adv2 & v1;
  assign out_valid = v2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1           <= 1'b0;
      v2           <= 1'b0;
      cw1          <= '0;
      out_data     <= '0;
      out_single   <= 1'b0;
      out_double   <= 1'b0;
      out_syndrome <= '0;
    end else begin
      if (adv1) begin
        v1 <= accept;
        if (accept) cw1 <= enc ^ inj_mask;
      end
      if (adv2) begin
        v2 <= v1;
        if (v1) begin
          out_data     <= dec_data;
          out_single   <= dec_single;
          out_double   <= dec_double;
          out_syndrome <= syn;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr_cnt) begin
      single_cnt <= '0;
      double_cnt <= '0;
    end else begin
      if (ld2 && dec_single && (single_cnt != '1)) single_cnt <= single_cnt + CNT_W'(1);
      if (ld2 && dec_double && (double_cnt != '1)) double_cnt <= double_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hamming_secded_pipe.sv
// Scoreboard bench for hamming_secded_pipe: a default-width instance and a
// 2-bit-counter instance share the same stimulus.
module tb_hamming_secded_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready, in_ready2;
  logic [31:0] in_data = '0;
  logic [1:0]  inj_mode = '0;
  logic [5:0]  inj_pos = '0;
  logic        out_valid, out_valid2;
  logic        out_ready = 1'b0;
  logic [31:0] out_data, out_data2;
  logic        out_single, out_single2;
  logic        out_double, out_double2;
  logic [5:0]  out_syndrome, out_syndrome2;
  logic        clr_cnt = 1'b0;
  logic [15:0] single_cnt, double_cnt;
  logic [1:0]  single_cnt2, double_cnt2;

  always #5 clk = ~clk;

  hamming_secded_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .inj_mode(inj_mode), .inj_pos(inj_pos),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_single(out_single), .out_double(out_double), .out_syndrome(out_syndrome),
    .clr_cnt(clr_cnt), .single_cnt(single_cnt), .double_cnt(double_cnt)
  );

  hamming_secded_pipe #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .inj_mode(inj_mode), .inj_pos(inj_pos),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
    .out_single(out_single2), .out_double(out_double2), .out_syndrome(out_syndrome2),
    .clr_cnt(clr_cnt), .single_cnt(single_cnt2), .double_cnt(double_cnt2)
  );

  typedef struct {
    logic [31:0] d;
    logic        s;
    logic        db;
    logic [5:0]  syn;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_s16 = 0, m_d16 = 0, m_s2 = 0, m_d2 = 0;
  bit   rnd_ready = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference codec written straight from the codeword definition.
  function automatic exp_t model(input logic [31:0] d, input logic [1:0] m, input int pos);
    logic [38:0] c;
    logic        pb;
    int          j, s, nxt;
    exp_t        e;
    c = '0;
    j = 0;
    for (int i = 1; i < 39; i++)
      if ((i & (i - 1)) != 0) begin c[i] = d[j]; j++; end
    for (int k = 0; k < 6; k++) begin
      pb = 1'b0;
      for (int i = 1; i < 39; i++)
        if ((i & (1 << k)) != 0) pb ^= c[i];
      c[1 << k] = pb;
    end
    c[0] = ^c[38:1];
    if (m == 2'b01 || m == 2'b10)
      if (pos < 39) c[pos] = ~c[pos];
    if (m == 2'b10) begin
      nxt = (pos + 1) % 39;
      c[nxt] = ~c[nxt];
    end
    s = 0;
    for (int i = 1; i < 39; i++)
      if (c[i]) s ^= i;
    pb = ^c;
    e.s   = pb && (s < 39);
    e.db  = (pb && s >= 39) || (!pb && s != 0);
    e.syn = 6'(s);
    if (e.s && s != 0) c[s] = ~c[s];
    j = 0;
    for (int i = 1; i < 39; i++)
      if ((i & (i - 1)) != 0) begin e.d[j] = c[i]; j++; end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q.delete();
      m_s16 = 0; m_d16 = 0; m_s2 = 0; m_d2 = 0;
    end else begin
      if (clr_cnt) begin
        m_s16 = 0; m_d16 = 0; m_s2 = 0; m_d2 = 0;
      end
      if (out_valid) begin
        if (q.size() == 0) chk("spurious_out", 1, 0);
        else begin
          chk("out_data", out_data, q[0].d);
          chk("out_single", out_single, q[0].s);
          chk("out_double", out_double, q[0].db);
          chk("out_syndrome", out_syndrome, q[0].syn);
          if (out_ready) void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        e = model(in_data, inj_mode, int'(inj_pos));
        q.push_back(e);
        if (e.s) begin
          if (m_s16 < 65535) m_s16++;
          if (m_s2 < 3) m_s2++;
        end
        if (e.db) begin
          if (m_d16 < 65535) m_d16++;
          if (m_d2 < 3) m_d2++;
        end
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic [1:0] m, input int pos);
    bit acc;
    int n;
    in_valid = 1'b1; in_data = d; inj_mode = m; inj_pos = 6'(pos);
    acc = 0;
    n = 0;
    while (!acc && n < 40) begin
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    inj_mode = 2'b00;
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((q.size() != 0 || out_valid) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) chk("drain_timeout", q.size(), 0);
  endtask

  task automatic chk_cnts(input string tag);
    chk({tag, "_s16"}, single_cnt, m_s16);
    chk({tag, "_d16"}, double_cnt, m_d16);
    chk({tag, "_s2"}, single_cnt2, m_s2);
    chk({tag, "_d2"}, double_cnt2, m_d2);
  endtask

  initial begin
    int idx;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_data", out_data, 0);
    chk("rst_flags", {out_single, out_double, out_syndrome}, 0);
    chk("rst_cnts", {single_cnt, double_cnt, single_cnt2, double_cnt2}, 0);
    @(posedge clk); #1;

    out_ready = 1'b1;
    send(32'hDEADBEEF, 2'b00, 0);
    @(negedge clk);
    chk("lat_c1_valid", out_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lat_c2_valid", out_valid, 1);
    chk("lat_c2_data", out_data, 32'hDEADBEEF);
    drain();

    send(32'h12345678, 2'b01, 5);
    drain();
    chk("single_pos5_cnt", single_cnt, 1);
    send(32'h12345678, 2'b01, 0);
    drain();
    chk("single_pos0_cnt", single_cnt, 2);
    send(32'hA5A5A5A5, 2'b10, 3);
    drain();
    chk("double_pos3_cnt", double_cnt, 1);
    send(32'hA5A5A5A5, 2'b01, 45);
    send(32'h0F0F0F0F, 2'b11, 7);
    send(32'hFFFFFFFF, 2'b01, 38);
    send(32'h80000001, 2'b10, 38);
    drain();
    chk_cnts("directed");

    rnd_ready = 1;
    for (int i = 0; i < 24; i++)
      send($urandom, 2'($urandom_range(0, 3)), int'($urandom_range(0, 45)));
    rnd_ready = 0;
    drain();
    chk_cnts("random");

    out_ready = 1'b0;
    idx = 0;
    for (int t = 0; t < 6; t++) begin
      in_valid = 1'b1;
      in_data = 32'(idx + 1);
      @(negedge clk);
      if (in_ready) idx++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("bp_accepts", idx, 2);
    @(negedge clk);
    chk("bp_in_ready", in_ready, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(32'h3, 2'b00, 0);
    send(32'h4, 2'b00, 0);
    drain();

    clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    @(negedge clk);
    chk("clr_single", single_cnt, 0);
    chk("clr_double", double_cnt, 0);
    @(posedge clk); #1;
    for (int i = 1; i <= 5; i++) send(32'h1000 + 32'(i), 2'b01, i + 10);
    drain();
    chk("sat_single2", single_cnt2, 3);
    chk("sat_single16", single_cnt, 5);
    send(32'h600D, 2'b01, 9);
    clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    drain();
    chk("clr_win_s2", single_cnt2, 0);
    chk("clr_win_s16", single_cnt, 0);

    send(32'hCAFE0001, 2'b01, 5);
    send(32'hCAFE0002, 2'b10, 20);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_cnts", {single_cnt, double_cnt, single_cnt2, double_cnt2}, 0);
    repeat (6) begin @(posedge clk); #1; end
    send(32'h13579BDF, 2'b00, 0);
    drain();
    chk_cnts("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hamming_secded_pipe.md
Name: hamming_secded_pipe

Overview:
- Parametrised, pipelined SECDED Hamming codec for the RISC-V datapath. Successor to the combinational 32-bit encode/inject/correct/decode chain.
- Adds:
  - generic data width;
  - overall-parity double-error detection;
  - positional single/double error injection;
  - valid/ready handshaking with backpressure;
  - saturating error counters for fault-injection campaigns.
- Sits between a producer (register file or memory write path) and a consumer. Returns corrected data plus error status.

Parameters:
- DATA_W, 32, data word width.
- PAR_W, 6, Hamming parity bits. Must satisfy 2^PAR_W >= DATA_W+PAR_W+1.
- CNT_W, 16, width of each error counter.
- Derived (localparam): CW = DATA_W+PAR_W+1 (39 at defaults); POS_W = clog2(CW).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept a word this cycle.
- in_data  in  DATA_W  data to encode.
- inj_mode  in  2  00 none, 01 single, 10 double, 11 reserved (treated as none).
- inj_pos  in  POS_W  codeword bit index for injection.
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer accepts the output word.
- out_data  out  DATA_W  decoded/corrected data.
- out_single  out  1  single error detected and corrected.
- out_double  out  1  uncorrectable error detected.
- out_syndrome  out  PAR_W  Hamming syndrome of the received word.
- clr_cnt  in  1  synchronous clear of both counters.
- single_cnt  out  CNT_W  count of single errors, saturating.
- double_cnt  out  CNT_W  count of double errors, saturating.

Behaviour:
- Codeword layout:
  - bit 0 is overall parity;
  - bits 1..CW-1 are the Hamming positions;
  - parity bits sit at power-of-two positions 1,2,4,...;
  - data bits fill the remaining positions in ascending order, with in_data[0] at position 3.
  - Parity bit 2^k = XOR of all positions with index bit k set.
  - Bit 0 = XOR of bits 1..CW-1, so the whole word has even parity.
- Reset (rst_n=0 at a clk edge):
  - both pipeline valids, out_valid, out_data, out_single, out_double, out_syndrome, single_cnt and double_cnt go to 0;
  - in_ready=1 in the first cycle after reset;
  - any in-flight words are discarded.
- Pipeline:
  - Stage 1 registers the encoded codeword with injection applied.
  - Stage 2 registers the syndrome, correction and extraction results.
  - Latency: 2 cycles from accept to out_valid with out_ready held high. Throughput is 1 word per cycle.
- Handshake:
  - adv2 = !v2 | out_ready; adv1 = !v1 | adv2; in_ready = adv1.
  - A word is accepted when in_valid & in_ready.
  - The output transfers when out_valid & out_ready.
  - Outputs are held stable while out_valid=1 and out_ready=0.
  - No word is lost or duplicated.
- Injection (sampled on accept, applied before the stage-1 register):
  - mode 01 flips bit inj_pos;
  - mode 10 flips bits inj_pos and (inj_pos+1) mod CW;
  - any flip index >= CW is ignored (no flip).
- Decode (stage 2 input):
  - s = XOR of indices of all set bits in positions 1..CW-1; p = XOR of all CW bits.
  - s=0, p=0: clean; flags 0.
  - p=1, s=0: bit 0 is in error; data unchanged; out_single=1.
  - p=1, 0<s<CW: flip position s, then extract; out_single=1.
  - p=1, s>=CW: out_double=1; no correction.
  - p=0, s!=0: out_double=1; data extracted uncorrected.
  - out_syndrome = s in all cases.
- Counters:
  - increment when stage 2 loads a word whose result is single (single_cnt) or double (double_cnt);
  - saturate at 2^CNT_W-1;
  - clr_cnt=1 zeroes both, and wins over a simultaneous increment.
- Stall behaviour: holding in_valid=1 while in_ready=0 has no effect. inj_mode and inj_pos are ignored when no accept occurs.

Test Plan:
- in_data=0xDEADBEEF, mode 00, out_ready=1 -> two cycles later out_valid=1, out_data=0xDEADBEEF, flags 0, syndrome 0.
- 0x12345678, mode 01, pos 5 -> out_data=0x12345678, out_single=1, syndrome=5, single_cnt=1; pos 0 -> syndrome 0, out_single=1, single_cnt=2.
- 0xA5A5A5A5, mode 10, pos 3 (bits 3,4 flipped) -> out_double=1, syndrome=7, double_cnt=1, no correction applied; mode 01 with pos 45 -> clean, flags 0.
- Backpressure: stream 0x1,0x2,0x3,0x4 with out_ready=0 -> in_ready drops after 2 accepts; release out_ready -> outputs 0x1..0x4 in order, none dropped or duplicated, data stable during the stall.
- CNT_W=2: five single-error words -> single_cnt=3 (saturated); clr_cnt pulsed on the cycle of a sixth single-error word -> single_cnt=0.
- rst_n=0 with two words in flight -> next cycle out_valid=0, counters 0, in_ready=1; no stale word emerges afterwards.
